wb_mul8_responder: RTL
======================

# wb_mul8_responder

Wishbone slave responder that gives the management SoC a proper register-mapped, handshaked path to an 8×8 unsigned multiplier. It latches operands, runs a low-power sequential shift-add multiply, and returns the 20-bit result field with a correct `wbs_ack_o`. It sits inside `user_project_wrapper` between the Wishbone MI A slave port and the multiplier datapath.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h3000_0000. Block decodes `wbs_adr_i[31:4] == BASE_ADDR[31:4]`.

Ports:
- `wb_clk_i`  in  1  — sole clock
- `wb_rst_ni`  in  1  — asynchronous, active-low reset
- `wbs_stb_i`  in  1  — strobe
- `wbs_cyc_i`  in  1  — bus cycle
- `wbs_we_i`  in  1  — write enable
- `wbs_sel_i`  in  4  — byte selects
- `wbs_adr_i`  in  32  — byte address
- `wbs_dat_i`  in  32  — write data
- `wbs_ack_o`  out  1  — single-cycle acknowledge
- `wbs_dat_o`  out  32  — read data
- `user_irq_o`  out  1  — done interrupt; present only with `MUL8_IRQ_EN`

## Operation
- Register map, word offset `wbs_adr_i[3:2]`:
  - 0x0 OPS (RW): [7:0] B, [15:8] A, [31:16] read 0. Writes honour `wbs_sel_i[0]` (B) and `wbs_sel_i[1]` (A).
  - 0x4 CTRL: bit0 START (W1, reads 0), bit1 BUSY (RO), bit2 DONE (W1C), bit3 IRQ_EN (RW, only with macro, else reads 0). Writes are gated by `wbs_sel_i[0]`.
  - 0x8 RESULT (RO): [19:0] PO, where [15:0] = A×B and [19:16] = 0. Bits [31:20] read 0.
  - 0xC reads 0. Writes to it are ignored.
- FSM states:
  - IDLE –START→ RUN.
  - RUN, 8 cycles, with `cnt` counting 0..7. At `cnt==7`, → DONE and load RESULT.
  - DONE –START→ RUN.
  - DONE –W1C of DONE→ IDLE.
- START latches OPS into the core at the moment it is accepted. OPS writes during RUN update OPS only and do not affect the multiply in flight.
- START during RUN is ignored.
- START in the same write as a DONE clear: START wins, DONE=0, FSM → RUN.
- Each RUN cycle:
  - If the multiplier LSB is 1, the accumulator adds the shifted multiplicand.
  - If the LSB is 0, the adder inputs are held (operand isolation) and the accumulator is not enabled.
- RESULT holds its value until the next completion.
- Reset clears OPS, RESULT, DONE, IRQ_EN, `cnt` and `ack`, and sets FSM to IDLE. Reset during RUN abandons the multiply.

## Timing
- A request is a cycle T with `stb & cyc & addr-hit & !wbs_ack_o`.
  - `wbs_ack_o`=1 in T+1 only, then 0.
  - Read data is registered and valid with ack.
  - Writes take effect at the T/T+1 edge.
- Back-to-back requests are acked every other cycle.
- No ack on an address miss.
- If `stb`/`cyc` drops mid-request, ack still fires once; the master ignores it.
- START accepted in T:
  - BUSY=1 in T+1.
  - RUN occupies T+1..T+8.
  - DONE=1 and RESULT valid from T+9.
  - BUSY=0 from T+9.
- A read of CTRL acked in cycle X returns the status sampled at edge X.
- Reset values: `wbs_ack_o`=0, `wbs_dat_o`=0, `user_irq_o`=0.

## Configuration
- `MUL8_IRQ_EN` defined:
  - CTRL.IRQ_EN exists.
  - `user_irq_o` is a registered `DONE & IRQ_EN`, rising in T+10 after START accepted in T.
  - `user_irq_o` clears one cycle after DONE is cleared.
- `MUL8_IRQ_EN` undefined: no IRQ_EN bit, no `user_irq_o` port, and the wrapper ties `user_irq` to 0.

## Structure
- `mul8_pkg`: register offset constants (`OFS_OPS`, `OFS_CTRL`, `OFS_RESULT`), CTRL bit indices, FSM state enum (`ST_IDLE`, `ST_RUN`, `ST_DONE`), `PO_W`=20.
- Sub-module `mul8_seq`: the shift-add core.
  - Inputs: `start`, `a`, `b`.
  - Outputs: `done` pulse, `product[15:0]`.
  - Same clock and reset.
- Bus decode, registers and FSM live in the top module.

## Test plan
- Write OPS=0x0000_0C0B, then CTRL=0x1 → ack one cycle after each request. BUSY=1 for 8 cycles. RESULT reads 0x0000_0084 (12×11).
- A=0xFF, B=0xFF, START → RESULT=0x0000_FE01 and bits [19:16]=0. Reading 0xC returns 0.
- START during RUN, plus an OPS write of 0x0202 during RUN → first result unchanged (0x84). A following START yields 0x0004.
- DONE set; write CTRL=0x5 (START and clear DONE) → DONE=0 and BUSY=1 next cycle. New result appears 8 cycles later.
- `wb_rst_ni` pulsed low at RUN cycle 4 → all outputs 0 immediately, FSM IDLE, RESULT=0, no DONE afterwards.
- With `MUL8_IRQ_EN`: IRQ_EN=1, START → `user_irq_o` rises 10 cycles after START acceptance. W1C of DONE → `user_irq_o` falls the next cycle.

Source files
------------

// File: rtl/mul8_pkg.sv
// Shared constants for the Wishbone 8x8 multiplier responder:
// register word offsets, CTRL bit positions, FSM states, result width.
package mul8_pkg;

  localparam int PO_W = 20;

  // Word offsets taken from wbs_adr_i[3:2]
  localparam logic [1:0] OFS_OPS    = 2'd0;
  localparam logic [1:0] OFS_CTRL   = 2'd1;
  localparam logic [1:0] OFS_RESULT = 2'd2;

  // CTRL register bit positions
  localparam int CTRL_START  = 0;
  localparam int CTRL_BUSY   = 1;
  localparam int CTRL_DONE   = 2;
  localparam int CTRL_IRQ_EN = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul8_seq.sv
// Sequential shift-add 8x8 unsigned multiplier core.
// start latches a/b; eight cycles later done pulses for one cycle
// while product carries the final sum.
module mul8_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        done,
  output logic [15:0] product
);

  logic [15:0] mcand_q, mcand_d;
  logic [7:0]  mplier_q, mplier_d;
  logic [15:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [15:0] addend;
  logic [15:0] sum;

  // Operand isolation: the addend stays at zero unless the multiplier
  // LSB calls for an add, so the adder inputs do not toggle needlessly.
  assign addend  = mcand_q & {16{mplier_q[0]}};
  assign sum     = acc_q + addend;
  // The last add is folded into product so the result is ready in the
  // final RUN cycle rather than one cycle later.
  assign done    = busy_q & (cnt_q == 3'd7);
  assign product = sum;

  // Next-state for the shift-add datapath
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = {8'h00, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_d = sum;
      mcand_d  = {mcand_q[14:0], 1'b0};
      mplier_d = {1'b0, mplier_q[7:1]};
      cnt_d    = cnt_q + 3'd1;
      if (cnt_q == 3'd7) busy_d = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/wb_mul8_responder.sv
// Wishbone slave front end for the sequential 8x8 multiplier: address
// decode, OPS/CTRL/RESULT registers, control FSM and single-cycle ack.
// Optional feature macro: MUL8_IRQ_EN adds CTRL.IRQ_EN and user_irq_o.
module wb_mul8_responder
  import mul8_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o
`ifdef MUL8_IRQ_EN
  ,
  output logic        user_irq_o
`endif
);

  state_e          state_q, state_d;
  logic [7:0]      a_q, a_d, b_q, b_d;
  logic [PO_W-1:0] result_q, result_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic [31:0]     rdata;
  logic            irq_en;

  logic            hit, req, wr, rd, ctrl_wr, start_acc, clr_done;
  logic [1:0]      ofs;
  logic            core_done;
  logic [15:0]     core_product;
  logic            busy, done;
  logic            unused_ok;

  assign unused_ok = ^{wbs_sel_i[3:2], wbs_dat_i[31:16], wbs_adr_i[1:0]};

  // A new request is refused while the previous ack is on the bus, which
  // paces back-to-back transfers to one every other cycle.
  assign hit     = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign req     = wbs_stb_i & wbs_cyc_i & hit & ~ack_q;
  assign wr      = req & wbs_we_i;
  assign rd      = req & ~wbs_we_i;
  assign ofs     = wbs_adr_i[3:2];
  assign ctrl_wr = wr & (ofs == OFS_CTRL) & wbs_sel_i[0];

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign start_acc = ctrl_wr & wbs_dat_i[CTRL_START] & ~busy;
  assign clr_done  = ctrl_wr & wbs_dat_i[CTRL_DONE];

  mul8_seq u_seq (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .start   (start_acc),
    .a       (a_q),
    .b       (b_q),
    .done    (core_done),
    .product (core_product)
  );

  // Control FSM next state; a START in the same write as a DONE clear wins
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_acc) state_d = ST_RUN;
      ST_RUN:  if (core_done) state_d = ST_DONE;
      ST_DONE: begin
        if (start_acc)     state_d = ST_RUN;
        else if (clr_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control FSM state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Read mux: status reflects the cycle in which the request is presented
  always_comb begin
    rdata = '0;
    case (ofs)
      OFS_OPS:    rdata[15:0] = {a_q, b_q};
      OFS_CTRL: begin
        rdata[CTRL_BUSY]   = busy;
        rdata[CTRL_DONE]   = done;
        rdata[CTRL_IRQ_EN] = irq_en;
      end
      OFS_RESULT: rdata[PO_W-1:0] = result_q;
      default:    rdata = '0;
    endcase
  end

  // Register-file and bus-response next values
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    ack_d    = req;
    dat_d    = rd ? rdata : 32'h0;
    if (wr && ofs == OFS_OPS) begin
      if (wbs_sel_i[0]) b_d = wbs_dat_i[7:0];
      if (wbs_sel_i[1]) a_d = wbs_dat_i[15:8];
    end
    if (core_done) result_d = {{(PO_W-16){1'b0}}, core_product};
  end

  // Register file and bus response registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

`ifdef MUL8_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q, irq_d;

  // Interrupt enable and the registered done interrupt
  always_comb begin
    irq_en_d = irq_en_q;
    if (ctrl_wr) irq_en_d = wbs_dat_i[CTRL_IRQ_EN];
    irq_d = done & irq_en_q;
  end

  // Interrupt registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_en     = irq_en_q;
  assign user_irq_o = irq_q;
`else
  assign irq_en = 1'b0;
`endif

endmodule
